vram_wr_arbiter: RTL and testbench

VRAM_WR_ARBITER -- requirements
Module: vram_wr_arbiter

---
 rtl/vram_wr_arbiter_pkg.sv | 25 ++
 rtl/vram_wr_arbiter_rr.sv | 34 +++
 rtl/vram_wr_arbiter.sv | 135 +++++++++++++
 tb/tb_vram_wr_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/vram_wr_arbiter_pkg.sv
// Shared definitions for the video RAM write arbiter: screen geometry, cell
// layout, requester indices and the clear-sweep FSM states.
package vram_wr_arbiter_pkg;

  localparam int SCREEN_COLS  = 70;
  localparam int SCREEN_ROWS  = 30;
  localparam int SCREEN_DEPTH = SCREEN_COLS * SCREEN_ROWS;

  // A cell is {color[2:0], ascii[7:0]}.
  localparam int COLOR_W = 3;
  localparam int ASCII_W = 8;
  localparam int CELL_W  = COLOR_W + ASCII_W;

  localparam int NUM_REQ    = 3;
  localparam int REQ_STATUS = 0;
  localparam int REQ_FALL   = 1;
  localparam int REQ_LIGHT  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/vram_wr_arbiter_rr.sv
// Three-way round-robin grant: the search starts at the requester after the
// last one granted, so each requester waits at most two others.
module rr_arbiter3
  import vram_wr_arbiter_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [2:0] gnt
);

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    gnt = '0;
    case (last)
      2'd0: begin
        if      (req[REQ_FALL])   gnt[REQ_FALL]   = 1'b1;
        else if (req[REQ_LIGHT])  gnt[REQ_LIGHT]  = 1'b1;
        else if (req[REQ_STATUS]) gnt[REQ_STATUS] = 1'b1;
      end
      2'd1: begin
        if      (req[REQ_LIGHT])  gnt[REQ_LIGHT]  = 1'b1;
        else if (req[REQ_STATUS]) gnt[REQ_STATUS] = 1'b1;
        else if (req[REQ_FALL])   gnt[REQ_FALL]   = 1'b1;
      end
      default: begin
        if      (req[REQ_STATUS]) gnt[REQ_STATUS] = 1'b1;
        else if (req[REQ_FALL])   gnt[REQ_FALL]   = 1'b1;
        else if (req[REQ_LIGHT])  gnt[REQ_LIGHT]  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/vram_wr_arbiter.sv
// Single-port video RAM write arbiter: round-robin between three writers,
// with a full-screen clear sweep that pre-empts them.
module vram_wr_arbiter
  import vram_wr_arbiter_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = CELL_W,
  parameter int DEPTH  = SCREEN_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2:0]              req_valid,
  input  logic [3*ADDR_W-1:0]     req_addr,
  input  logic [3*DATA_W-1:0]     req_data,
  output logic [2:0]              req_ready,
  input  logic                    clr_start,
  output logic                    clr_busy,
  output logic                    clr_done,
  output logic                    wr_en,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic [DATA_W-1:0]       wr_data,
  output logic [7:0]              drop_cnt
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic [1:0]          last_q, last_d;
  logic [7:0]          drop_q, drop_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;

  logic [2:0]          gnt;
  logic                hs;
  logic [1:0]          sel_idx;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_data;

  rr_arbiter3 u_rr (
    .req  (req_valid),
    .last (last_q),
    .gnt  (gnt)
  );

  // Grants are only exposed in IDLE, outside reset, and when no clear is starting.
  assign req_ready = (rst_n && state_q == ST_IDLE && !clr_start) ? gnt : 3'b000;
  assign hs        = |req_ready;

  always_comb begin
    sel_idx  = 2'(REQ_STATUS);
    sel_addr = req_addr[REQ_STATUS*ADDR_W +: ADDR_W];
    sel_data = req_data[REQ_STATUS*DATA_W +: DATA_W];
    if (req_ready[REQ_FALL]) begin
      sel_idx  = 2'(REQ_FALL);
      sel_addr = req_addr[REQ_FALL*ADDR_W +: ADDR_W];
      sel_data = req_data[REQ_FALL*DATA_W +: DATA_W];
    end else if (req_ready[REQ_LIGHT]) begin
      sel_idx  = 2'(REQ_LIGHT);
      sel_addr = req_addr[REQ_LIGHT*ADDR_W +: ADDR_W];
      sel_data = req_data[REQ_LIGHT*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    last_d    = last_q;
    drop_d    = drop_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end else if (hs) begin
          last_d = sel_idx;
          // Off-screen writes still complete the handshake but never reach the RAM.
          if (sel_addr < DEPTH_A) begin
            wr_en_d   = 1'b1;
            wr_addr_d = sel_addr;
            wr_data_d = sel_data;
          end else if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
          end
        end
      end
      ST_CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = clr_cnt_q;
        wr_data_d = '0;
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == LAST_A) begin
          state_d   = ST_DONE;
          clr_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      clr_cnt_q <= '0;
      last_q    <= 2'd2;
      drop_q    <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      last_q    <= last_d;
      drop_q    <= drop_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign clr_busy = (state_q == ST_CLEAR);
  assign clr_done = (state_q == ST_DONE);
  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_vram_wr_arbiter.sv
// Directed bench for vram_wr_arbiter: round-robin order, latency, drops,
// clear sweep, reset abort and drop counter saturation.
module tb_vram_wr_arbiter;

  localparam int AW = 12;
  localparam int DW = 11;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [2:0]      req_valid;
  logic [3*AW-1:0] req_addr;
  logic [3*DW-1:0] req_data;
  logic [2:0]      req_ready;
  logic            clr_start;
  logic            clr_busy;
  logic            clr_done;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic [7:0]      drop_cnt;

  int n_checks = 0;
  int n_errors = 0;

  vram_wr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(2100)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .clr_start (clr_start),
    .clr_busy  (clr_busy),
    .clr_done  (clr_done),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  function automatic logic [AW-1:0] rr_addr(input logic [2:0] g);
    return (g == 3'b001) ? 12'd10 : (g == 3'b010) ? 12'd20 : 12'd30;
  endfunction

  function automatic logic [DW-1:0] rr_data(input logic [2:0] g);
    return (g == 3'b001) ? 11'h100 : (g == 3'b010) ? 11'h201 : 11'h302;
  endfunction

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] exp_g [6];
    int zero_cyc, wr_cnt, bad, done_cnt, busy_cnt, exp_a, found, resumed;

    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    rst_n = 1'b0; req_valid = 3'b111; req_addr = '0; req_data = '0; clr_start = 1'b0;
    tick(); tick();
    check("rst_ready", req_ready, 3'b000);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_busy_done", {clr_busy, clr_done}, 2'b00);
    check("rst_drop", drop_cnt, 0);
    rst_n = 1'b1; req_valid = 3'b000;

    // Round-robin with all three requesters held valid.
    tick();
    req_valid = 3'b111;
    set_req(0, 12'd10, 11'h100); set_req(1, 12'd20, 11'h201); set_req(2, 12'd30, 11'h302);
    for (int k = 0; k < 6; k++) begin
      #1;
      check($sformatf("rr_gnt%0d", k), req_ready, exp_g[k]);
      if (k > 0) begin
        check($sformatf("rr_wr_en%0d", k), wr_en, 1);
        check($sformatf("rr_wr_addr%0d", k), wr_addr, rr_addr(exp_g[k-1]));
        check($sformatf("rr_wr_data%0d", k), wr_data, rr_data(exp_g[k-1]));
      end
      tick();
    end
    req_valid = 3'b000;
    #1;
    check("rr_last_addr", wr_addr, 12'd30);
    check("rr_last_data", wr_data, 11'h302);
    check("idle_ready", req_ready, 3'b000);
    tick();
    check("idle_wr_en", wr_en, 0);

    // Single request, latency one.
    req_valid = 3'b001; set_req(0, 12'd8, 11'h04B);
    #1;
    check("single_ready", req_ready, 3'b001);
    tick();
    req_valid = 3'b000;
    check("single_wr_en", wr_en, 1);
    check("single_wr_addr", wr_addr, 12'd8);
    check("single_wr_data", wr_data, 11'h04B);

    // Last valid address is written, not dropped.
    tick();
    req_valid = 3'b001; set_req(0, 12'd2099, 11'h7FF);
    #1;
    check("edge_ready", req_ready, 3'b001);
    tick();
    req_valid = 3'b000;
    check("edge_wr_en", wr_en, 1);
    check("edge_wr_addr", wr_addr, 12'd2099);
    check("edge_drop", drop_cnt, 0);

    // Out-of-range writes.
    tick();
    req_valid = 3'b010; set_req(1, 12'd2100, 11'h001);
    #1;
    check("oor1_ready", req_ready, 3'b010);
    tick();
    set_req(1, 12'd4095, 11'h002);
    #1;
    check("oor2_ready", req_ready, 3'b010);
    check("oor1_wr_en", wr_en, 0);
    tick();
    req_valid = 3'b000;
    check("oor2_wr_en", wr_en, 0);
    check("oor_drop", drop_cnt, 2);

    // Clear sweep pre-empting three live requests; a second clr_start mid-sweep is ignored.
    tick();
    req_valid = 3'b111;
    set_req(0, 12'd10, 11'h100); set_req(1, 12'd20, 11'h201); set_req(2, 12'd30, 11'h302);
    clr_start = 1'b1;
    #1;
    check("clr_start_ready", req_ready, 3'b000);
    zero_cyc = 1; wr_cnt = 0; bad = 0; done_cnt = 0; busy_cnt = 0; exp_a = 0; resumed = 0;
    for (int i = 0; i < 2300; i++) begin
      tick();
      clr_start = (i == 500);
      #1;
      if (wr_en) begin
        wr_cnt++;
        if (wr_addr != AW'(exp_a) || wr_data != '0) bad++;
        exp_a++;
      end
      if (clr_done) done_cnt++;
      if (clr_busy) busy_cnt++;
      if (clr_busy && clr_done) bad++;
      if (req_ready != 3'b000) begin
        resumed = 1;
        break;
      end
      zero_cyc++;
    end
    clr_start = 1'b0;
    check("clr_resumed", resumed, 1);
    check("clr_zero_cycles", zero_cyc, 2102);
    check("clr_writes", wr_cnt, 2100);
    check("clr_bad_writes", bad, 0);
    check("clr_done_pulses", done_cnt, 1);
    check("clr_busy_cycles", busy_cnt, 2100);
    check("clr_resume_gnt", req_ready, 3'b100);
    tick();
    req_valid = 3'b000;
    check("clr_resume_wr_en", wr_en, 1);
    check("clr_resume_addr", wr_addr, 12'd30);

    // Reset while the sweep is issuing address 1000.
    tick();
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    found = 0;
    for (int i = 0; i < 1200; i++) begin
      if (wr_en && wr_addr == 12'd999) begin
        found = 1;
        break;
      end
      tick();
    end
    check("abort_reached_1000", found, 1);
    check("abort_busy_before", clr_busy, 1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("abort_busy", clr_busy, 0);
    check("abort_wr_en", wr_en, 0);
    done_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (clr_done || wr_en) done_cnt++;
      tick();
    end
    check("abort_no_done", done_cnt, 0);
    req_valid = 3'b111;
    #1;
    check("abort_ptr_reset", req_ready, 3'b001);

    // Drop counter saturation with requester 2 streaming off-screen addresses.
    req_valid = 3'b100; set_req(2, 12'd3000, 11'h0AA);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      #1;
      if (wr_en || req_ready != 3'b100) bad++;
      if (i == 100) check("sat_drop_100", drop_cnt, 100);
      if (i == 255) check("sat_drop_255", drop_cnt, 255);
      tick();
    end
    req_valid = 3'b000;
    check("sat_stream_bad", bad, 0);
    check("sat_drop_final", drop_cnt, 255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
